// File: rtl/shift_result_display.sv
// Four-digit multiplexed seven-segment display for the shifter result.
// Captures result on each rising edge of ready and scans one digit per REFRESH_DIV cycles.
module shift_result_display #(
   parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] result,
   input  logic [15:0] ready,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        new_value
);

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned DIG_W   = 2;
   localparam int unsigned SEG_W   = 7;

   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [NIB_W-1:0] AN_RESET  = 4'b1110;

   logic [DATA_W-1:0] disp_reg;
   logic              valid;
   logic              ready_q;
   logic [DATA_W-1:0] div_cnt;
   logic [DIG_W-1:0]  digit;

   logic              ready_c;
   logic              capture_c;
   logic              wrap_c;
   logic [NIB_W-1:0]  nibble_c;
   logic [NIB_W-1:0]  lead_zero_c;
   logic              blank_c;
   logic [SEG_W-1:0]  seg_c;
   logic [NIB_W-1:0]  an_c;
   logic              dp_c;

   // Active-low {g,f,e,d,c,b,a} hex glyphs
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] n);
      logic [SEG_W-1:0] s;
      s = SEG_BLANK;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Edge detect on ready and scan-timer wrap
   always_comb begin
      ready_c   = |ready;
      capture_c = ready_c & ~ready_q;
      wrap_c    = (div_cnt == DATA_W'(REFRESH_DIV - 16'd1));
   end

   // Select the nibble for the active digit and work out leading-zero blanking
   always_comb begin
      nibble_c = disp_reg[NIB_W-1:0];
      case (digit)
         2'd0: nibble_c = disp_reg[3:0];
         2'd1: nibble_c = disp_reg[7:4];
         2'd2: nibble_c = disp_reg[11:8];
         2'd3: nibble_c = disp_reg[15:12];
         default: nibble_c = disp_reg[3:0];
      endcase

      lead_zero_c    = '0;
      lead_zero_c[3] = (disp_reg[15:12] == 4'h0);
      lead_zero_c[2] = lead_zero_c[3] & (disp_reg[11:8] == 4'h0);
      lead_zero_c[1] = lead_zero_c[2] & (disp_reg[7:4]  == 4'h0);
      lead_zero_c[0] = 1'b0;

      blank_c = blank_lz & lead_zero_c[digit];
   end

   // Next registered display drive
   always_comb begin
      an_c = ~(4'b0001 << digit);
      dp_c = ~((digit == 2'd0) & valid);
      if (!valid)
         seg_c = SEG_DASH;
      else if (blank_c)
         seg_c = SEG_BLANK;
      else
         seg_c = hex_to_seg(nibble_c);
   end

   // Capture path, scan timer and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_reg  <= '0;
         valid     <= 1'b0;
         ready_q   <= 1'b0;
         div_cnt   <= '0;
         digit     <= '0;
         new_value <= 1'b0;
         an        <= AN_RESET;
         seg       <= SEG_DASH;
         dp        <= 1'b1;
      end else begin
         ready_q   <= ready_c;
         new_value <= capture_c;
         if (capture_c) begin
            disp_reg <= result;
            valid    <= 1'b1;
         end

         if (wrap_c) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
         end else begin
            div_cnt <= div_cnt + 16'd1;
         end

         an  <= an_c;
         seg <= seg_c;
         dp  <= dp_c;
      end
   end

endmodule
